// File: rtl/acc_cpu_seq_pkg.sv
// acc_cpu_seq_pkg: shared states, status codes, opcodes and halt-detector flag type
package acc_cpu_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLEAR, S_RUN, S_DONE} state_t;
  localparam logic [1:0] STAT_HALT    = 2'b00;
  localparam logic [1:0] STAT_RUNOFF  = 2'b01;
  localparam logic [1:0] STAT_TIMEOUT = 2'b10;
  localparam logic [1:0] STAT_LENERR  = 2'b11;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hA;
  typedef struct packed {
    logic halt;
    logic runoff;
    logic timeout;
  } flag_t;
  function automatic logic [1:0] flag_status(input flag_t f);
    return f.halt ? STAT_HALT : f.runoff ? STAT_RUNOFF : STAT_TIMEOUT;
  endfunction
endpackage

// File: rtl/acc_cpu_halt_detect.sv
// acc_cpu_halt_detect: watches cpu_pc during RUN and raises a one-hot halt/runoff/timeout flag
module acc_cpu_halt_detect
  import acc_cpu_seq_pkg::*;
#(
  parameter int TIMEOUT  = 255,
  parameter int HALT_WIN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       run,
  input  logic [3:0] cpu_pc,
  input  logic [3:0] len,
  output flag_t      flag
);
  localparam int SW = $clog2(HALT_WIN);
  logic [3:0] prev_pc;
  logic [SW-1:0] stable, stable_nxt;
  logic [7:0] run_cnt, run_nxt;
  logic halt, runoff, tmo;
  // a running CPU holds PC for at most 2 cycles, so a longer hold means HALT
  always_comb begin
    stable_nxt   = (cpu_pc == prev_pc) ? stable + SW'(1) : '0;
    run_nxt      = run_cnt + 8'd1;
    halt         = stable_nxt == SW'(HALT_WIN - 1);
    runoff       = cpu_pc > len;
    tmo          = run_nxt == 8'(TIMEOUT);
    flag.halt    = run & halt;
    flag.runoff  = run & ~halt & runoff;
    flag.timeout = run & ~halt & ~runoff & tmo;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_pc <= '0;
      stable  <= '0;
      run_cnt <= '0;
    end else if (clear) begin
      prev_pc <= '0;
      stable  <= '0;
      run_cnt <= '0;
    end else if (run) begin
      prev_pc <= cpu_pc;
      stable  <= stable_nxt;
      run_cnt <= run_nxt;
    end
  end
endmodule

// File: rtl/acc_cpu_sequencer.sv
// acc_cpu_sequencer: loads a program into the accumulator CPU, runs it and captures AC with a status code
module acc_cpu_sequencer
  import acc_cpu_seq_pkg::*;
#(
  parameter int DEPTH    = 10,
  parameter int TIMEOUT  = 255,
  parameter int HALT_WIN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  len,
  input  logic        in_valid,
  input  logic [11:0] in_data,
  output logic        in_ready,
  output logic        cpu_we,
  output logic [3:0]  cpu_addr,
  output logic [11:0] cpu_instr,
  output logic        cpu_rst,
  input  logic [3:0]  cpu_pc,
  input  logic [7:0]  cpu_ac,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output logic [7:0]  result
);
  localparam logic [3:0] DEPTH_L = 4'(DEPTH);
  state_t state;
  logic [3:0] len_q;
  logic len_bad;
  flag_t flag;
  assign len_bad   = (len == '0) || (len > DEPTH_L);
  assign cpu_we    = in_valid & in_ready;
  assign cpu_instr = in_ready ? in_data : '0;
  acc_cpu_halt_detect #(.TIMEOUT(TIMEOUT), .HALT_WIN(HALT_WIN)) u_halt (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == S_CLEAR),
    .run    (state == S_RUN),
    .cpu_pc (cpu_pc),
    .len    (len_q),
    .flag   (flag)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      len_q    <= '0;
      cpu_addr <= '0;
      in_ready <= 1'b0;
      cpu_rst  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      status   <= STAT_HALT;
      result   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          busy <= 1'b1;
          if (len_bad) begin
            status <= STAT_LENERR;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            len_q    <= len;
            cpu_addr <= '0;
            in_ready <= 1'b1;
            cpu_rst  <= 1'b0;
            state    <= S_LOAD;
          end
        end
        S_LOAD: if (cpu_we) begin
          cpu_addr <= cpu_addr + 4'd1;
          if (cpu_addr == len_q - 4'd1) begin
            in_ready <= 1'b0;
            cpu_rst  <= 1'b1;
            state    <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          cpu_rst <= 1'b0;
          state   <= S_RUN;
        end
        S_RUN: if (|flag) begin
          status  <= flag_status(flag);
          result  <= cpu_ac;
          cpu_rst <= 1'b1;
          done    <= 1'b1;
          state   <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
